spi_rect_fill: RTL and testbench

Parametrised successor to the init-only display top. After the panel is initialised, this block accepts a start request with a rectangle geometry and an RGB565 colour. It streams the column-address set (CASET), row-address set (RASET) and memory-write (RAMWR) command sequence over a 4-wire SPI link, followed by the fill pixels. It contains its own byte serializer and sits between the top-level sequencer and the panel pins, multiplexed with the init block by the top.

---
 rtl/spi_rect_fill.sv | 212 +++++++++++++++++++++
 tb/tb_spi_rect_fill.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rect_fill.sv
// Rectangle fill streamer for an SPI TFT panel: clips the requested rectangle,
// then serialises CASET/RASET/RAMWR and the fill pixels over SPI mode 0.
module spi_rect_fill #(
    parameter int CLK_DIV = 2,
    parameter int COORD_W = 9,
    parameter int H_RES   = 240,
    parameter int V_RES   = 320
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_w,
    input  logic [COORD_W-1:0] i_h,
    input  logic [15:0]        i_color,
    output logic               o_sclk,
    output logic               o_mosi,
    output logic               o_cs,
    output logic               o_dc,
    output logic               o_busy,
    output logic               o_done
);

    localparam int PIX_W = $clog2(H_RES * V_RES + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {IDLE, CLIP, CMD, ARGS, PIXELS, FINISH} state_t;

    state_t             state_reg;
    logic [COORD_W-1:0] x0_reg, y0_reg, w_reg, h_reg;
    logic [15:0]        color_reg, x1_reg, y1_reg;
    logic [PIX_W-1:0]   pix_left_reg;
    logic [3:0]         idx_reg;
    logic [7:0]         shift_reg;
    logic [2:0]         bit_cnt_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic               send_lo_reg;
    logic               tail_reg;

    logic [15:0] x0_16, y0_16;
    assign x0_16 = 16'(x0_reg);
    assign y0_16 = 16'(y0_reg);

    // Clipping arithmetic is done at 32 bits so H_RES - x0 never wraps for valid x0.
    logic [31:0] x0_ext, y0_ext, room_x, room_y, eff_w, eff_h, area;
    logic        rect_empty;
    logic [15:0] x1_next, y1_next;

    always_comb begin
        x0_ext     = 32'(x0_reg);
        y0_ext     = 32'(y0_reg);
        room_x     = 32'(H_RES) - x0_ext;
        room_y     = 32'(V_RES) - y0_ext;
        eff_w      = (32'(w_reg) < room_x) ? 32'(w_reg) : room_x;
        eff_h      = (32'(h_reg) < room_y) ? 32'(h_reg) : room_y;
        area       = eff_w * eff_h;
        rect_empty = (w_reg == '0) || (h_reg == '0) ||
                     (x0_ext >= 32'(H_RES)) || (y0_ext >= 32'(V_RES));
        x1_next    = 16'(x0_ext + eff_w - 32'd1);
        y1_next    = 16'(y0_ext + eff_h - 32'd1);
    end

    // Header byte that follows header byte idx_reg.
    logic [3:0] idx_next;
    logic [7:0] hdr_byte;
    logic       hdr_dc;

    always_comb begin
        idx_next = idx_reg + 4'd1;
        hdr_byte = CMD_RAMWR;
        hdr_dc   = 1'b1;
        case (idx_next)
            4'd1:    hdr_byte = x0_16[15:8];
            4'd2:    hdr_byte = x0_16[7:0];
            4'd3:    hdr_byte = x1_reg[15:8];
            4'd4:    hdr_byte = x1_reg[7:0];
            4'd5:    begin hdr_byte = CMD_RASET; hdr_dc = 1'b0; end
            4'd6:    hdr_byte = y0_16[15:8];
            4'd7:    hdr_byte = y0_16[7:0];
            4'd8:    hdr_byte = y1_reg[15:8];
            4'd9:    hdr_byte = y1_reg[7:0];
            default: begin hdr_byte = CMD_RAMWR; hdr_dc = 1'b0; end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            x0_reg       <= '0;
            y0_reg       <= '0;
            w_reg        <= '0;
            h_reg        <= '0;
            color_reg    <= '0;
            x1_reg       <= '0;
            y1_reg       <= '0;
            pix_left_reg <= '0;
            idx_reg      <= '0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            div_cnt_reg  <= '0;
            send_lo_reg  <= 1'b0;
            tail_reg     <= 1'b0;
            o_sclk       <= 1'b0;
            o_mosi       <= 1'b0;
            o_cs         <= 1'b1;
            o_dc         <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        x0_reg    <= i_x0;
                        y0_reg    <= i_y0;
                        w_reg     <= i_w;
                        h_reg     <= i_h;
                        color_reg <= i_color;
                        o_busy    <= 1'b1;
                        state_reg <= CLIP;
                    end
                end
                CLIP: begin
                    if (rect_empty) begin
                        o_done    <= 1'b1;
                        o_busy    <= 1'b0;
                        state_reg <= FINISH;
                    end else begin
                        // CS drops together with the first low half-period.
                        x1_reg       <= x1_next;
                        y1_reg       <= y1_next;
                        pix_left_reg <= PIX_W'(area);
                        idx_reg      <= '0;
                        shift_reg    <= CMD_CASET;
                        o_mosi       <= CMD_CASET[7];
                        o_dc         <= 1'b0;
                        o_cs         <= 1'b0;
                        o_sclk       <= 1'b0;
                        bit_cnt_reg  <= '0;
                        div_cnt_reg  <= '0;
                        tail_reg     <= 1'b0;
                        state_reg    <= CMD;
                    end
                end
                CMD, ARGS, PIXELS: begin
                    if (div_cnt_reg != DIV_LAST) begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end else begin
                        div_cnt_reg <= '0;
                        if (tail_reg) begin
                            tail_reg  <= 1'b0;
                            o_cs      <= 1'b1;
                            o_dc      <= 1'b0;
                            o_done    <= 1'b1;
                            o_busy    <= 1'b0;
                            state_reg <= FINISH;
                        end else if (!o_sclk) begin
                            o_sclk <= 1'b1;
                        end else begin
                            o_sclk <= 1'b0;
                            if (bit_cnt_reg != 3'd7) begin
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                o_mosi      <= shift_reg[6];
                            end else begin
                                bit_cnt_reg <= '0;
                                if (state_reg != PIXELS) begin
                                    if (idx_reg == 4'd10) begin
                                        shift_reg   <= color_reg[15:8];
                                        o_mosi      <= color_reg[15];
                                        o_dc        <= 1'b1;
                                        send_lo_reg <= 1'b1;
                                        state_reg   <= PIXELS;
                                    end else begin
                                        idx_reg   <= idx_next;
                                        shift_reg <= hdr_byte;
                                        o_mosi    <= hdr_byte[7];
                                        o_dc      <= hdr_dc;
                                        state_reg <= hdr_dc ? ARGS : CMD;
                                    end
                                end else if (send_lo_reg) begin
                                    shift_reg   <= color_reg[7:0];
                                    o_mosi      <= color_reg[7];
                                    send_lo_reg <= 1'b0;
                                end else if (pix_left_reg == PIX_W'(1)) begin
                                    // Last pixel sent: hold SCLK low one half-period before CS rises.
                                    tail_reg <= 1'b1;
                                    o_mosi   <= 1'b0;
                                end else begin
                                    pix_left_reg <= pix_left_reg - 1'b1;
                                    shift_reg    <= color_reg[15:8];
                                    o_mosi       <= color_reg[15];
                                    send_lo_reg  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rect_fill.sv
// Scoreboard bench for spi_rect_fill: a reference model queues the expected
// {dc,byte} stream, a bus monitor decodes bytes on rising SCLK.
module tb_spi_rect_fill;

    localparam int CLK_DIV = 2;
    localparam int COORD_W = 9;
    localparam int H_RES   = 240;
    localparam int V_RES   = 320;
    localparam int BUDGET  = 20000;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_start = 1'b0;
    logic [COORD_W-1:0] i_x0 = '0, i_y0 = '0, i_w = '0, i_h = '0;
    logic [15:0]        i_color = '0;
    logic o_sclk, o_mosi, o_cs, o_dc, o_busy, o_done;

    spi_rect_fill #(.CLK_DIV(CLK_DIV), .COORD_W(COORD_W), .H_RES(H_RES), .V_RES(V_RES)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_x0(i_x0), .i_y0(i_y0), .i_w(i_w), .i_h(i_h), .i_color(i_color),
        .o_sclk(o_sclk), .o_mosi(o_mosi), .o_cs(o_cs), .o_dc(o_dc),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int rise_cnt = 0, done_cnt = 0, cs_low_cycles = 0, glitch_cnt = 0, nbits = 0;
    logic [7:0] rx_sh = '0;
    logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_dc = 1'b0;

    // Bus monitor, sampled on the falling system clock edge.
    always @(negedge i_clk) begin
        if (i_rst) begin
            nbits = 0;
        end else begin
            if (o_sclk && !prev_sclk) begin
                rise_cnt++;
                rx_sh = {rx_sh[6:0], o_mosi};
                nbits++;
                if (nbits == 8) begin
                    rx_q.push_back({o_dc, rx_sh});
                    nbits = 0;
                end
            end
            if (o_sclk && prev_sclk && (o_mosi !== prev_mosi || o_dc !== prev_dc)) glitch_cnt++;
            if (!o_cs) cs_low_cycles++;
            if (o_done) done_cnt++;
        end
        prev_sclk = o_sclk;
        prev_mosi = o_mosi;
        prev_dc   = o_dc;
    end

    task automatic clear_stats();
        exp_q.delete();
        rx_q.delete();
        rise_cnt = 0; done_cnt = 0; cs_low_cycles = 0; glitch_cnt = 0;
    endtask

    task automatic model_push(input int x0, input int y0, input int w, input int h, input logic [15:0] c);
        int ew, eh, x1, y1;
        if (w == 0 || h == 0 || x0 >= H_RES || y0 >= V_RES) return;
        ew = (w > H_RES - x0) ? H_RES - x0 : w;
        eh = (h > V_RES - y0) ? V_RES - y0 : h;
        x1 = x0 + ew - 1;
        y1 = y0 + eh - 1;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'(x0 >> 8)}); exp_q.push_back({1'b1, 8'(x0)});
        exp_q.push_back({1'b1, 8'(x1 >> 8)}); exp_q.push_back({1'b1, 8'(x1)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'(y0 >> 8)}); exp_q.push_back({1'b1, 8'(y0)});
        exp_q.push_back({1'b1, 8'(y1 >> 8)}); exp_q.push_back({1'b1, 8'(y1)});
        exp_q.push_back({1'b0, 8'h2C});
        for (int p = 0; p < ew * eh; p++) begin
            exp_q.push_back({1'b1, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
        end
    endtask

    task automatic start_frame(input int x0, input int y0, input int w, input int h, input logic [15:0] c);
        @(negedge i_clk);
        i_x0 = COORD_W'(x0); i_y0 = COORD_W'(y0); i_w = COORD_W'(w); i_h = COORD_W'(h);
        i_color = c;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit timeout);
        cycles = 0;
        timeout = 1'b1;
        for (int k = 1; k <= BUDGET; k++) begin
            if (o_done) begin
                cycles = k;
                timeout = 1'b0;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_cs, o_sclk, o_mosi, o_dc, o_busy, o_done} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got=%06b want=100000", {o_cs, o_sclk, o_mosi, o_dc, o_busy, o_done});
        end
        i_rst = 1'b0;
        clear_stats();
        bad = 0;
        repeat (1000) begin
            @(negedge i_clk);
            if (o_cs !== 1'b1 || o_sclk !== 1'b0 || o_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL idle_outputs got=%0d bad cycles want=0", bad); end
        checks++;
        if (rise_cnt != 0) begin failures++; $display("FAIL idle_sclk got=%0d edges want=0", rise_cnt); end
    endtask

    task automatic test_frames();
        int tx0[2] = '{10, 230};
        int ty0[2] = '{20, 0};
        int tw[2]  = '{2, 20};
        int th[2]  = '{1, 1};
        logic [15:0] tc[2] = '{16'hF800, 16'h07E0};
        int cyc, n;
        bit to;
        logic [8:0] e, a;
        for (int t = 0; t < 2; t++) begin
            clear_stats();
            model_push(tx0[t], ty0[t], tw[t], th[t], tc[t]);
            n = exp_q.size();
            start_frame(tx0[t], ty0[t], tw[t], th[t], tc[t]);
            wait_done(cyc, to);
            checks++;
            if (to) begin failures++; $display("FAIL frame%0d_timeout got=none want=done", t); end
            checks++;
            if (o_busy !== 1'b0) begin failures++; $display("FAIL frame%0d_busy_at_done got=%b want=0", t, o_busy); end
            repeat (5) @(negedge i_clk);
            checks++;
            if (rx_q.size() != n) begin failures++; $display("FAIL frame%0d_len got=%0d want=%0d", t, rx_q.size(), n); end
            for (int i = 0; i < n && rx_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                a = rx_q.pop_front();
                checks++;
                if (a !== e) begin failures++; $display("FAIL frame%0d_byte%0d got=%03h want=%03h", t, i, a, e); end
            end
            checks++;
            if (cs_low_cycles != n * 16 * CLK_DIV + CLK_DIV) begin
                failures++;
                $display("FAIL frame%0d_cs_low got=%0d want=%0d", t, cs_low_cycles, n * 16 * CLK_DIV + CLK_DIV);
            end
            checks++;
            if (done_cnt != 1) begin failures++; $display("FAIL frame%0d_done_count got=%0d want=1", t, done_cnt); end
            checks++;
            if (glitch_cnt != 0) begin failures++; $display("FAIL frame%0d_data_while_high got=%0d want=0", t, glitch_cnt); end
        end
    endtask

    task automatic test_empty();
        int ex0[2] = '{5, 250};
        int ew[2]  = '{0, 4};
        int cyc;
        bit to;
        for (int t = 0; t < 2; t++) begin
            clear_stats();
            start_frame(ex0[t], 5, ew[t], 3, 16'hFFFF);
            wait_done(cyc, to);
            checks++;
            if (to || cyc > 3) begin failures++; $display("FAIL empty%0d_latency got=%0d want<=3", t, cyc); end
            repeat (5) @(negedge i_clk);
            checks++;
            if (rise_cnt != 0 || cs_low_cycles != 0) begin
                failures++;
                $display("FAIL empty%0d_bus got=%0d edges %0d cs_low want=0 0", t, rise_cnt, cs_low_cycles);
            end
            checks++;
            if (done_cnt != 1) begin failures++; $display("FAIL empty%0d_done_count got=%0d want=1", t, done_cnt); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, n;
        bit to;
        logic [8:0] e, a;
        clear_stats();
        model_push(10, 20, 2, 1, 16'hF800);
        model_push(1, 2, 1, 1, 16'hABCD);
        n = exp_q.size();
        start_frame(10, 20, 2, 1, 16'hF800);
        repeat (100) @(negedge i_clk);
        start_frame(0, 0, 5, 5, 16'h1234);
        wait_done(cyc, to);
        checks++;
        if (to) begin failures++; $display("FAIL b2b_first_timeout got=none want=done"); end
        start_frame(1, 2, 1, 1, 16'hABCD);
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%b want=1", o_busy); end
        wait_done(cyc, to);
        checks++;
        if (to) begin failures++; $display("FAIL b2b_second_timeout got=none want=done"); end
        repeat (5) @(negedge i_clk);
        checks++;
        if (rx_q.size() != n) begin failures++; $display("FAIL b2b_len got=%0d want=%0d", rx_q.size(), n); end
        for (int i = 0; i < n && rx_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL b2b_byte%0d got=%03h want=%03h", i, a, e); end
        end
        checks++;
        if (done_cnt != 2) begin failures++; $display("FAIL b2b_done_count got=%0d want=2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int cyc, n, edges, k;
        bit to;
        logic [8:0] e, a;
        clear_stats();
        start_frame(0, 0, 4, 4, 16'h5555);
        k = 0;
        while (rx_q.size() < 13 && k < BUDGET) begin
            @(negedge i_clk);
            k++;
        end
        checks++;
        if (rx_q.size() < 13) begin failures++; $display("FAIL rstmid_reach_pixels got=%0d bytes want>=13", rx_q.size()); end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_cs, o_sclk, o_busy} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_outputs got=%03b want=100", {o_cs, o_sclk, o_busy});
        end
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        edges = rise_cnt;
        repeat (20) @(negedge i_clk);
        checks++;
        if (rise_cnt != edges) begin failures++; $display("FAIL rstmid_no_edges got=%0d want=%0d", rise_cnt, edges); end
        clear_stats();
        model_push(3, 4, 2, 2, 16'hA5C3);
        n = exp_q.size();
        start_frame(3, 4, 2, 2, 16'hA5C3);
        wait_done(cyc, to);
        checks++;
        if (to) begin failures++; $display("FAIL rstmid_timeout got=none want=done"); end
        repeat (5) @(negedge i_clk);
        checks++;
        if (rx_q.size() != n) begin failures++; $display("FAIL rstmid_len got=%0d want=%0d", rx_q.size(), n); end
        for (int i = 0; i < n && rx_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            a = rx_q.pop_front();
            checks++;
            if (a !== e) begin failures++; $display("FAIL rstmid_byte%0d got=%03h want=%03h", i, a, e); end
        end
    endtask

    task automatic test_random();
        int x0, y0, w, h, cyc, n;
        logic [15:0] c;
        bit to;
        logic [8:0] e, a;
        for (int t = 0; t < 8; t++) begin
            clear_stats();
            x0 = $urandom_range(0, 260);
            y0 = $urandom_range(0, 330);
            if (t < 4) begin x0 = $urandom_range(225, 239); y0 = $urandom_range(310, 319); end
            w = $urandom_range(0, 20);
            h = $urandom_range(0, 12);
            c = 16'($urandom);
            model_push(x0, y0, w, h, c);
            n = exp_q.size();
            start_frame(x0, y0, w, h, c);
            wait_done(cyc, to);
            checks++;
            if (to) begin failures++; $display("FAIL rand%0d_timeout got=none want=done", t); end
            repeat (5) @(negedge i_clk);
            checks++;
            if (rx_q.size() != n) begin failures++; $display("FAIL rand%0d_len got=%0d want=%0d", t, rx_q.size(), n); end
            for (int i = 0; i < n && rx_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                a = rx_q.pop_front();
                checks++;
                if (a !== e) begin failures++; $display("FAIL rand%0d_byte%0d got=%03h want=%03h", t, i, a, e); end
            end
            $display("rand%0d x0=%0d y0=%0d w=%0d h=%0d bytes=%0d", t, x0, y0, w, h, n);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
